usb_tx_crc16_appender: RTL and testbench

- Transmit-side CRC-16 generator for the USB bulk endpoint TX path. It is the counterpart of the RX CRC-16 checker.
- Passes the serial, LSB-first, unstuffed data-payload bits through unchanged, accumulating CRC-16 (x^16+x^15+x^2+1, preset all-ones) as they go.
- After the last data bit, appends the 16-bit inverted CRC field.
- Sits between the TX byte serializer and the bit-stuffer/NRZI encoder. It advances only on the bit-time strobe.

---
 rtl/usb_crc_pkg.sv | 22 ++
 rtl/crc16_lfsr_step.sv | 31 +++
 rtl/usb_tx_crc16_appender.sv | 164 ++++++++++++++++
 tb/tb_usb_tx_crc16_appender.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared CRC-16 constants, FSM state type and a single-bit LFSR step for the USB TX/RX CRC path.
// The LFSR is in MSB-first shift-register form, fed with LSB-first wire data.
package usb_crc_pkg;

    localparam int          CRC16_LEN     = 16;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } tx_crc_state_t;

    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic        din,
                                               input logic [15:0] poly);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_lfsr_step.sv
// Bit-serial CRC-16 register: one polynomial step per en, preset has priority over en.
// Latency: updated value visible the cycle after en; no backpressure.
module crc16_lfsr_step
    import usb_crc_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        preset,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= INIT;
        end else if (preset) begin
            r_crc <= INIT;
        end else if (en) begin
            r_crc <= crc16_next(r_crc, din, POLY);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/usb_tx_crc16_appender.sv
// USB TX CRC-16 appender: echoes payload bits, then the inverted CRC LSB-first; USB_TX_CRC_SELFCHECK_EN adds a residue self-check.
// Latency: each bit is emitted on the edge sampling its shift_en; no backpressure, paced solely by shift_en.
module usb_tx_crc16_appender
    import usb_crc_pkg::*;
#(
    parameter logic [15:0] POLY    = CRC16_POLY,
    parameter logic [15:0] INIT    = CRC16_INIT,
    parameter logic [15:0] RESIDUE = CRC16_RESIDUE
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        shift_en,
    input  logic        start,
    input  logic        zero_len,
    input  logic        data_bit,
    input  logic        data_last,
    input  logic        abort,
    output logic        tx_bit,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] crc_out,
    output logic        crc_err
);

    localparam int CNT_W = $clog2(CRC16_LEN);

    tx_crc_state_t    r_state;
    logic             r_busy;
    logic             r_tx_bit;
    logic             r_tx_valid;
    logic             r_done;
    logic [15:0]      r_shift;
    logic [CNT_W-1:0] r_cnt;

    logic             w_start_ok;
    logic             w_gen_en;
    logic             w_emit;
    logic             w_emit_bit;
    logic             w_last_crc;
    logic [15:0]      w_lfsr;
    logic [15:0]      w_lfsr_next;

    // A start is only honoured once busy has fully dropped, i.e. not in the done cycle.
    assign w_start_ok  = start & ~abort & ~r_busy & (r_state == IDLE);
    assign w_gen_en    = shift_en & ~abort & (r_state == DATA);
    assign w_emit      = shift_en & ~abort & ((r_state == DATA) | (r_state == CRC));
    assign w_emit_bit  = (r_state == DATA) ? data_bit : r_shift[15];
    assign w_last_crc  = w_emit & (r_state == CRC) & (r_cnt == CNT_W'(CRC16_LEN - 1));
    assign w_lfsr_next = crc16_next(w_lfsr, data_bit, POLY);

    crc16_lfsr_step #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_gen (
        .clk    (clk),
        .n_rst  (n_rst),
        .preset (w_start_ok),
        .en     (w_gen_en),
        .din    (data_bit),
        .crc    (w_lfsr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
        end else begin
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                if (w_emit) begin
                    r_tx_bit   <= w_emit_bit;
                    r_tx_valid <= 1'b1;
                end
                case (r_state)
                    IDLE: begin
                        if (w_start_ok) begin
                            r_busy <= 1'b1;
                            r_cnt  <= '0;
                            if (zero_len) begin
                                r_shift <= ~INIT;
                                r_state <= CRC;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end
                    DATA: begin
                        // Snapshot the CRC including the final bit so the field follows with no idle strobe.
                        if (shift_en && data_last) begin
                            r_shift <= ~w_lfsr_next;
                            r_cnt   <= '0;
                            r_state <= CRC;
                        end
                    end
                    CRC: begin
                        if (shift_en) begin
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_cnt   <= r_cnt + 1'b1;
                            if (w_last_crc) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef USB_TX_CRC_SELFCHECK_EN
    logic [15:0] w_chk_crc;
    logic        r_crc_err;

    crc16_lfsr_step #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_chk (
        .clk    (clk),
        .n_rst  (n_rst),
        .preset (w_start_ok),
        .en     (w_emit),
        .din    (w_emit_bit),
        .crc    (w_chk_crc)
    );

    // Fold the last CRC bit in combinationally so the verdict lands together with done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc_err <= 1'b0;
        end else if (w_start_ok) begin
            r_crc_err <= 1'b0;
        end else if (w_last_crc) begin
            r_crc_err <= (crc16_next(w_chk_crc, w_emit_bit, POLY) != RESIDUE);
        end
    end

    assign crc_err = r_crc_err;
`else
    logic [15:0] w_unused_residue;
    assign w_unused_residue = RESIDUE;
    assign crc_err          = 1'b0;
`endif

    assign tx_bit   = r_tx_bit;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign crc_out  = w_lfsr;

endmodule

// File: tb/tb_usb_tx_crc16_appender.sv
// Directed bench for usb_tx_crc16_appender; reference CRC uses the reflected (0xA001) formulation.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
module tb_usb_tx_crc16_appender;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        shift_en, start, zero_len, data_bit, data_last, abort;
    logic        tx_bit, tx_valid, busy, done, crc_err;
    logic [15:0] crc_out;

    always #5 clk = ~clk;

    usb_tx_crc16_appender dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .shift_en  (shift_en),
        .start     (start),
        .zero_len  (zero_len),
        .data_bit  (data_bit),
        .data_last (data_last),
        .abort     (abort),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done),
        .crc_out   (crc_out),
        .crc_err   (crc_err)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic       q_bits[$];
    int         nvld, ndone, done_idx, nstrobe_busy;
    logic [7:0] msg[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bit(input logic [15:0] r, input logic b);
        logic [15:0] t;
        t = r ^ {15'd0, b};
        return t[0] ? ((t >> 1) ^ 16'hA001) : (t >> 1);
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] o;
        for (int k = 0; k < 16; k++) o[k] = v[15-k];
        return o;
    endfunction

    function automatic logic [15:0] model_reg(input int nbits);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int k = 0; k < nbits; k++) r = ref_bit(r, msg[k/8][k%8]);
        return r;
    endfunction

    task automatic clear_mon();
        q_bits.delete();
        nvld = 0; ndone = 0; done_idx = -1; nstrobe_busy = 0;
    endtask

    task automatic cyc(input logic se, input logic db, input logic dl,
                       input logic st, input logic zl, input logic ab);
        shift_en = se; data_bit = db; data_last = dl; start = st; zero_len = zl; abort = ab;
        if (se && busy) nstrobe_busy++;
        @(posedge clk);
        #1;
        if (tx_valid) begin q_bits.push_back(tx_bit); nvld++; end
        if (done) begin ndone++; done_idx = q_bits.size(); end
        shift_en = 1'b0; start = 1'b0; abort = 1'b0; data_last = 1'b0; zero_len = 1'b0;
    endtask

    task automatic run_pkt(input int nbytes, input int gap, input int corrupt_idx, input int restart_idx);
        int nb;
        nb = nbytes * 8;
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < nb; i++) begin
            for (int g = 1; g < gap; g++) cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0, 0);
            if (i == restart_idx) begin
                cyc(0, 0, 0, 1, 0, 0);
                check("start_while_busy_ignored", {31'd0, busy}, 32'd1);
            end
`ifdef USB_TX_CRC_SELFCHECK_EN
            if (i == corrupt_idx) begin
                force dut.w_emit_bit = ~msg[i/8][i%8];
                cyc(1, msg[i/8][i%8], (i == nb - 1), 0, 0, 0);
                release dut.w_emit_bit;
            end else begin
                cyc(1, msg[i/8][i%8], (i == nb - 1), 0, 0, 0);
            end
`else
            if (corrupt_idx >= 0 && i == corrupt_idx) $display("note: corruption needs the self-check build");
            cyc(1, msg[i/8][i%8], (i == nb - 1), 0, 0, 0);
`endif
        end
        for (int i = 0; i < 16; i++) begin
            for (int g = 1; g < gap; g++) cyc(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
            cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end
    endtask

    task automatic check_pkt(input string tag, input int nbytes);
        logic [15:0] r, field, got_field;
        int          nb, errs;
        nb    = nbytes * 8;
        r     = model_reg(nb);
        field = r ^ 16'hFFFF;
        errs  = 0;
        got_field = 16'h0;
        for (int i = 0; i < nb; i++)
            if (i < q_bits.size() && q_bits[i] !== msg[i/8][i%8]) errs++;
        for (int k = 0; k < 16; k++)
            if (nb + k < q_bits.size()) got_field[k] = q_bits[nb + k];
        check({tag, "_nbits"}, q_bits.size(), nb + 16);
        check({tag, "_data_echo_errs"}, errs, 0);
        check({tag, "_crc_field"}, {16'd0, got_field}, {16'd0, field});
        check({tag, "_done_index"}, done_idx, nb + 16);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_crc_out"}, {16'd0, crc_out}, {16'd0, bitrev16(r)});
        check({tag, "_crc_err"}, {31'd0, crc_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] ascii[9];
        logic [7:0] first8;
        int         zeros;
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        n_rst = 1'b0; shift_en = 0; start = 0; zero_len = 0; data_bit = 0; data_last = 0; abort = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_bit", {31'd0, tx_bit}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_crc_out", {16'd0, crc_out}, 32'h0000FFFF);
        check("rst_crc_err", {31'd0, crc_err}, 32'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted in the middle of the payload.
        for (int i = 0; i < 9; i++) msg[i] = ascii[i];
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, msg[0][i], 0, 0, 0, 0);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_tx_bit", {31'd0, tx_bit}, 32'd0);
        check("midrst_crc_out", {16'd0, crc_out}, 32'h0000FFFF);
        @(posedge clk);
        #1 n_rst = 1'b1;
        clear_mon();
        repeat (6) cyc(1, 1, 1, 0, 0, 0);
        check("postrst_no_tx_valid", nvld, 0);
        check("postrst_busy", {31'd0, busy}, 32'd0);

        // "123456789", dense strobes.
        clear_mon();
        run_pkt(9, 1, -1, -1);
        check_pkt("ascii", 9);
        check("ascii_crc_B4C8", {16'd0, bitrev16(crc_out) ^ 16'hFFFF}, 32'h0000B4C8);
        first8 = 8'h00;
        for (int k = 0; k < 8; k++) if (72 + k < q_bits.size()) first8[7-k] = q_bits[72 + k];
        check("ascii_first_crc_bits", {24'd0, first8}, {24'd0, 8'b00010011});
        check("ascii_busy_at_done", {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        check("ascii_busy_after", {31'd0, busy}, 32'd0);

        // Zero-length packet.
        clear_mon();
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        zeros = 0;
        foreach (q_bits[k]) if (q_bits[k] === 1'b0) zeros++;
        check("zlp_nbits", q_bits.size(), 16);
        check("zlp_zero_bits", zeros, 16);
        check("zlp_done_index", done_idx, 16);
        check("zlp_crc_err", {31'd0, crc_err}, 32'd0);
        check("zlp_crc_out", {16'd0, crc_out}, 32'h0000FFFF);
        cyc(0, 0, 0, 0, 0, 0);

        // Sparse strobes, data_last and data_bit wiggled on non-strobe cycles.
        clear_mon();
        run_pkt(9, 4, -1, -1);
        check_pkt("sparse", 9);
        check("sparse_valid_eq_strobes", nvld, nstrobe_busy);
        cyc(0, 0, 0, 0, 0, 0);

        // Abort after 10 data bits; lfsr must hold.
        msg[0] = 8'h31; msg[1] = 8'h32;
        clear_mon();
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, msg[i/8][i%8], 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_crc_held", {16'd0, crc_out}, {16'd0, bitrev16(model_reg(10))});
        for (int i = 0; i < 20; i++) cyc(1, 1'($urandom_range(0, 1)), (i % 3 == 0), 0, 0, 0);
        check("abort_no_done", ndone, 0);
        check("abort_valid_count", nvld, 10);
        cyc(0, 0, 0, 1, 0, 1);
        check("abort_start_same_cycle", {31'd0, busy}, 32'd0);
        msg[0] = 8'h00;
        clear_mon();
        run_pkt(1, 1, -1, -1);
        check_pkt("zero_byte", 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Start while busy, then strobes while idle.
        msg[0] = 8'hA5;
        clear_mon();
        run_pkt(1, 1, -1, 3);
        check_pkt("restart", 1);
        cyc(0, 0, 0, 0, 0, 0);
        clear_mon();
        repeat (5) cyc(1, 1, 1, 0, 0, 0);
        check("idle_no_tx_valid", nvld, 0);
        check("idle_crc_unchanged", {16'd0, crc_out}, {16'd0, bitrev16(model_reg(8))});

`ifdef USB_TX_CRC_SELFCHECK_EN
        msg[0] = 8'h00;
        clear_mon();
        run_pkt(1, 1, 3, -1);
        check("selfcheck_done", ndone, 1);
        check("selfcheck_crc_err", {31'd0, crc_err}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
